// File: rtl/fifo_arb_tx.sv
// Transmit-side arbiter: merges two read-registered client FIFOs into one output FIFO,
// granting round-robin at packet boundaries and rewriting header select bits per client.
module fifo_arb_tx #(
    parameter int                DWIDTH    = 8,
    parameter logic [DWIDTH-1:0] SELMASK   = 8'h80,
    parameter logic [DWIDTH-1:0] CNTMASK   = 8'h70,
    parameter bit                SEL_FORCE = 1'b1
) (
    input  logic              CLK,
    input  logic              RESETn,
    output logic              c1_rden,
    input  logic              c1_rdempty,
    input  logic [DWIDTH-1:0] c1_rddata,
    output logic              c2_rden,
    input  logic              c2_rdempty,
    input  logic [DWIDTH-1:0] c2_rddata,
    output logic              fifo_wren,
    input  logic              fifo_wrfull,
    output logic [DWIDTH-1:0] fifo_wrdata,
    output logic [1:0]        gnt,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, HDR, DATA_RD, DATA_WR} state_t;

    function automatic int lowBit(input logic [DWIDTH-1:0] mask);
        int pos;
        pos = 0;
        for (int i = DWIDTH - 1; i >= 0; i--) begin
            if (mask[i]) pos = i;
        end
        return pos;
    endfunction

    localparam int CSHIFT = lowBit(CNTMASK);

    // Reserved count codes collapse to a header-only packet.
    function automatic logic [3:0] decodeCnt(input logic [DWIDTH-1:0] hdr);
        logic [2:0] field;
        field = 3'(hdr >> CSHIFT);
        case (field)
            3'd1:    return 4'd1;
            3'd2:    return 4'd2;
            3'd3:    return 4'd4;
            3'd4:    return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

    state_t            r_state;
    state_t            w_stateNext;
    logic [3:0]        r_dcnt;
    logic [3:0]        w_dcntNext;
    logic [1:0]        r_gnt;
    logic [1:0]        w_gntNext;
    logic              r_lastC2;
    logic              w_lastC2Next;
    logic              w_c1Rd;
    logic              w_c2Rd;
    logic              w_wren;
    logic [DWIDTH-1:0] w_wrdata;
    logic [DWIDTH-1:0] w_grantData;
    logic              w_grantEmpty;
    logic [DWIDTH-1:0] w_hdrOut;
    logic [3:0]        w_hdrCnt;
    logic              w_pickC2;

    assign w_grantData  = r_gnt[1] ? c2_rddata  : c1_rddata;
    assign w_grantEmpty = r_gnt[1] ? c2_rdempty : c1_rdempty;
    assign w_hdrCnt     = decodeCnt(w_grantData);
    assign w_pickC2     = !c2_rdempty && (c1_rdempty || !r_lastC2);

    always_comb begin
        w_hdrOut = w_grantData;
        if (SEL_FORCE) begin
            w_hdrOut = r_gnt[0] ? (w_grantData | SELMASK) : (w_grantData & ~SELMASK);
        end
    end

    always_comb begin
        w_stateNext  = r_state;
        w_dcntNext   = r_dcnt;
        w_gntNext    = r_gnt;
        w_lastC2Next = r_lastC2;
        w_c1Rd       = 1'b0;
        w_c2Rd       = 1'b0;
        w_wren       = 1'b0;
        w_wrdata     = w_grantData;
        case (r_state)
            IDLE: begin
                if ((!c1_rdempty || !c2_rdempty) && !fifo_wrfull) begin
                    w_c1Rd       = !w_pickC2;
                    w_c2Rd       = w_pickC2;
                    w_gntNext    = w_pickC2 ? 2'b10 : 2'b01;
                    w_lastC2Next = w_pickC2;
                    w_stateNext  = HDR;
                end
            end
            HDR: begin
                w_wren     = 1'b1;
                w_wrdata   = w_hdrOut;
                w_dcntNext = w_hdrCnt;
                if (w_hdrCnt == 4'd0) begin
                    w_stateNext = IDLE;
                    w_gntNext   = 2'b00;
                end else begin
                    w_stateNext = DATA_RD;
                end
            end
            DATA_RD: begin
                // The grant is held here even if the other client has data waiting.
                if (!w_grantEmpty && !fifo_wrfull) begin
                    w_c1Rd      = r_gnt[0];
                    w_c2Rd      = r_gnt[1];
                    w_stateNext = DATA_WR;
                end
            end
            DATA_WR: begin
                w_wren     = 1'b1;
                w_dcntNext = r_dcnt - 4'd1;
                if (r_dcnt <= 4'd1) begin
                    w_stateNext = IDLE;
                    w_gntNext   = 2'b00;
                end else begin
                    w_stateNext = DATA_RD;
                end
            end
            default: begin
                w_stateNext = IDLE;
                w_gntNext   = 2'b00;
            end
        endcase
        if (!RESETn) begin
            w_c1Rd = 1'b0;
            w_c2Rd = 1'b0;
            w_wren = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            r_state  <= IDLE;
            r_dcnt   <= 4'd0;
            r_gnt    <= 2'b00;
            r_lastC2 <= 1'b1;
        end else begin
            r_state  <= w_stateNext;
            r_dcnt   <= w_dcntNext;
            r_gnt    <= w_gntNext;
            r_lastC2 <= w_lastC2Next;
        end
    end

    assign c1_rden     = w_c1Rd;
    assign c2_rden     = w_c2Rd;
    assign fifo_wren   = w_wren;
    assign fifo_wrdata = w_wrdata;
    assign gnt         = r_gnt;
    assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_fifo_arb_tx.sv
// Randomized and directed bench for fifo_arb_tx: client FIFOs are queues, and the expected
// output stream is built packet-by-packet from the round-robin and header rewrite rules.
module tb_fifo_arb_tx;

    logic       CLK;
    logic       RESETn;
    logic       c1_rden, c2_rden, c1_rdempty, c2_rdempty;
    logic [7:0] c1_rddata, c2_rddata;
    logic       fifo_wren, fifo_wrfull;
    logic [7:0] fifo_wrdata;
    logic [1:0] gnt;
    logic       busy;

    logic       p_c1Rden, p_c2Rden, p_wren, p_busy, pC2Empty;
    logic [7:0] p_wrdata;
    logic [1:0] p_gnt;

    fifo_arb_tx dut (
        .CLK(CLK), .RESETn(RESETn),
        .c1_rden(c1_rden), .c1_rdempty(c1_rdempty), .c1_rddata(c1_rddata),
        .c2_rden(c2_rden), .c2_rdempty(c2_rdempty), .c2_rddata(c2_rddata),
        .fifo_wren(fifo_wren), .fifo_wrfull(fifo_wrfull), .fifo_wrdata(fifo_wrdata),
        .gnt(gnt), .busy(busy)
    );

    fifo_arb_tx #(.SEL_FORCE(1'b0)) dutPass (
        .CLK(CLK), .RESETn(RESETn),
        .c1_rden(p_c1Rden), .c1_rdempty(1'b1), .c1_rddata(8'h00),
        .c2_rden(p_c2Rden), .c2_rdempty(pC2Empty), .c2_rddata(8'h80),
        .fifo_wren(p_wren), .fifo_wrfull(1'b0), .fifo_wrdata(p_wrdata),
        .gnt(p_gnt), .busy(p_busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [7:0] q1[$], q2[$], m1[$], m2[$], expQ[$], late[$];
    int   passCount = 0, checkCount = 0;
    int   cyc = 0, wrCount = 0, lastWrCyc = 0, mLast = 2;
    logic cap1 = 0, cap2 = 0, prevRd = 0, prevFull = 0;
    logic randMode = 0, fullReq = 0, hold1 = 0, hold2 = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic int pktDataLen(input logic [7:0] hdr);
        int field;
        field = (int'(hdr) / 16) % 8;
        if (field >= 1 && field <= 4) return 1 << (field - 1);
        return 0;
    endfunction

    task automatic pushPkt(input int client, input logic [7:0] hdr);
        logic [7:0] d;
        int n;
        n = pktDataLen(hdr);
        if (client == 1) begin m1.push_back(hdr); q1.push_back(hdr); end
        else             begin m2.push_back(hdr); q2.push_back(hdr); end
        for (int i = 0; i < n; i++) begin
            d = 8'($urandom);
            if (client == 1) begin m1.push_back(d); q1.push_back(d); end
            else             begin m2.push_back(d); q2.push_back(d); end
        end
    endtask

    // Whole packets alternate between clients that still have one queued.
    task automatic buildExpected();
        int pick, n;
        logic [7:0] h;
        while (m1.size() > 0 || m2.size() > 0) begin
            if (m1.size() > 0 && m2.size() > 0) pick = (mLast == 1) ? 2 : 1;
            else pick = (m1.size() > 0) ? 1 : 2;
            mLast = pick;
            if (pick == 1) begin
                h = m1.pop_front();
                expQ.push_back(h | 8'h80);
                n = pktDataLen(h);
                repeat (n) expQ.push_back(m1.pop_front());
            end else begin
                h = m2.pop_front();
                expQ.push_back(h & 8'h7F);
                n = pktDataLen(h);
                repeat (n) expQ.push_back(m2.pop_front());
            end
        end
    endtask

    task automatic sampleEdge();
        logic [7:0] e;
        @(negedge CLK);
        cyc++;
        if (RESETn) begin
            if (c1_rden || c2_rden) begin
                checkOutput("rdenOneHot", 32'(c1_rden & c2_rden), 0);
                if (c1_rden) checkOutput("rd1WhenEmpty", 32'(c1_rdempty), 0);
                if (c2_rden) checkOutput("rd2WhenEmpty", 32'(c2_rdempty), 0);
            end
            if (fifo_wren) begin
                wrCount++;
                lastWrCyc = cyc;
                checkOutput("wrAfterRd", 32'(prevRd), 1);
                checkOutput("fullAtRd", 32'(prevFull), 0);
                if (expQ.size() == 0) checkOutput("extraWrite", 32'(fifo_wren), 0);
                else begin
                    e = expQ.pop_front();
                    checkOutput("wrdata", 32'(fifo_wrdata), 32'(e));
                end
            end
            if (busy) checkOutput("gntOneHot", 32'($onehot(gnt)), 1);
        end
        prevRd   = RESETn && (c1_rden || c2_rden);
        prevFull = fifo_wrfull;
        cap1     = c1_rden;
        cap2     = c2_rden;
    endtask

    task automatic applyStimulus();
        @(posedge CLK);
        #1;
        if (cap1 && q1.size() > 0) c1_rddata = q1.pop_front();
        if (cap2 && q2.size() > 0) c2_rddata = q2.pop_front();
        hold1 = randMode && busy && ($urandom_range(0, 2) == 0);
        hold2 = randMode && busy && ($urandom_range(0, 2) == 0);
        c1_rdempty  = (q1.size() == 0) || hold1;
        c2_rdempty  = (q2.size() == 0) || hold2;
        fifo_wrfull = randMode ? ($urandom_range(0, 3) == 0) : fullReq;
    endtask

    task automatic drain(input string tag, input int maxCyc);
        int n;
        n = 0;
        while ((expQ.size() > 0 || busy) && n < maxCyc) begin
            sampleEdge();
            applyStimulus();
            n++;
        end
        checkOutput({tag, "Left"}, expQ.size(), 0);
        checkOutput({tag, "Idle"}, 32'(busy), 0);
    endtask

    initial begin
        int start, w0, n;
        logic seen;
        RESETn = 0; fifo_wrfull = 0; c1_rdempty = 1; c2_rdempty = 1;
        c1_rddata = 0; c2_rddata = 0; pC2Empty = 1;
        repeat (2) begin sampleEdge(); applyStimulus(); end

        // Single-byte packet from c1 across reset release
        pushPkt(1, 8'h00);
        buildExpected();
        sampleEdge(); applyStimulus();
        sampleEdge();
        checkOutput("rstC1Rden", 32'(c1_rden), 0);
        checkOutput("rstWren", 32'(fifo_wren), 0);
        checkOutput("rstBusy", 32'(busy), 0);
        checkOutput("rstGnt", 32'(gnt), 0);
        applyStimulus();
        RESETn = 1;
        sampleEdge();
        checkOutput("t1Rden", 32'(c1_rden), 1);
        checkOutput("t1C2Rden", 32'(c2_rden), 0);
        applyStimulus(); sampleEdge();
        checkOutput("t1Wren", 32'(fifo_wren), 1);
        checkOutput("t1Data", 32'(fifo_wrdata), 32'h80);
        checkOutput("t1Gnt", 32'(gnt), 32'b01);
        applyStimulus(); sampleEdge();
        checkOutput("t1Busy", 32'(busy), 0);
        checkOutput("t1GntClr", 32'(gnt), 0);
        applyStimulus();

        // Passthrough instance keeps c2 header unchanged
        pC2Empty = 0;
        seen = 0; n = 0;
        while (!seen && n < 10) begin
            sampleEdge();
            if (p_c2Rden) seen = 1;
            applyStimulus();
            n++;
        end
        pC2Empty = 1;
        checkOutput("ptRead", 32'(seen), 1);
        sampleEdge();
        checkOutput("ptWren", 32'(p_wren), 1);
        checkOutput("ptData", 32'(p_wrdata), 32'h80);
        applyStimulus();

        // c2 header with count field 3: 4 data bytes over 10 cycles
        pushPkt(2, 8'hB5);
        buildExpected();
        start = -1; n = 0;
        while ((expQ.size() > 0 || busy || start < 0) && n < 40) begin
            sampleEdge();
            checkOutput("t2C1Rden", 32'(c1_rden), 0);
            if (c2_rden && start < 0) start = cyc;
            applyStimulus();
            n++;
        end
        checkOutput("t2Left", expQ.size(), 0);
        checkOutput("t2Span", 32'(lastWrCyc - start), 9);

        // Fairness: three single-byte packets per client
        for (int i = 1; i <= 3; i++) begin
            pushPkt(1, 8'(i));
            pushPkt(2, 8'(8'h80 + i));
        end
        buildExpected();
        drain("fair", 100);

        // Mid-packet starvation of c1 plus output-full stall while c2 waits
        m1.push_back(8'h40); q1.push_back(8'h40);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            m1.push_back(d);
            if (i < 3) q1.push_back(d); else late.push_back(d);
        end
        pushPkt(2, 8'h90);
        buildExpected();
        w0 = wrCount; n = 0;
        while (wrCount - w0 < 4 && n < 40) begin
            sampleEdge(); applyStimulus(); n++;
        end
        checkOutput("stallReach", wrCount - w0, 4);
        for (int i = 0; i < 7; i++) begin
            fullReq = (i < 5);
            sampleEdge();
            checkOutput("stallC2Rden", 32'(c2_rden), 0);
            checkOutput("stallWren", 32'(fifo_wren), 0);
            applyStimulus();
        end
        fullReq = 0;
        while (late.size() > 0) q1.push_back(late.pop_front());
        drain("stall", 100);

        // Reserved count code gives a header-only packet
        pushPkt(1, 8'h60);
        pushPkt(1, 8'h10);
        buildExpected();
        drain("rsvd", 60);

        // Randomized traffic with output-full and client-empty stalls
        for (int p = 0; p < 6; p++) begin
            pushPkt(1, 8'($urandom));
            pushPkt(2, 8'($urandom));
        end
        buildExpected();
        randMode = 1;
        drain("rand", 4000);
        randMode = 0;

        // Reset during an 8-byte packet, then c1 must win the first tie again
        pushPkt(1, 8'h40);
        buildExpected();
        w0 = wrCount; seen = 0; n = 0;
        while (!seen && n < 40) begin
            sampleEdge();
            if (wrCount - w0 >= 3 && c1_rden) seen = 1;
            applyStimulus();
            n++;
        end
        checkOutput("mrReach", 32'(seen), 1);
        RESETn = 0;
        sampleEdge();
        checkOutput("mrWren", 32'(fifo_wren), 0);
        checkOutput("mrC1Rden", 32'(c1_rden), 0);
        checkOutput("mrC2Rden", 32'(c2_rden), 0);
        applyStimulus(); sampleEdge();
        checkOutput("mrBusy", 32'(busy), 0);
        checkOutput("mrGnt", 32'(gnt), 0);
        applyStimulus();
        q1.delete(); q2.delete(); m1.delete(); m2.delete(); expQ.delete();
        mLast = 2;
        RESETn = 1;
        pushPkt(2, 8'h02);
        pushPkt(1, 8'h01);
        buildExpected();
        drain("mrTie", 60);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
